// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, R-type funcs,
// ALU codes, instruction classes, FSM states and the Moore strobe decode.
package multicycle_control_pkg;

  localparam int OPC_W_DEF  = 6;
  localparam int FUNC_W_DEF = 6;

  localparam logic [5:0] OPC_RTYPE = 6'b100000;
  localparam logic [5:0] OPC_LI    = 6'b111000;
  localparam logic [5:0] OPC_LUI   = 6'b111001;
  localparam logic [5:0] OPC_ADDI  = 6'b110000;
  localparam logic [5:0] OPC_ANDI  = 6'b110010;
  localparam logic [5:0] OPC_ORI   = 6'b110011;
  localparam logic [5:0] OPC_LW    = 6'b001111;
  localparam logic [5:0] OPC_SW    = 6'b011111;
  localparam logic [5:0] OPC_BEQ   = 6'b000000;
  localparam logic [5:0] OPC_BNE   = 6'b000001;
  localparam logic [5:0] OPC_B     = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b110000;
  localparam logic [5:0] FN_SUB = 6'b110001;
  localparam logic [5:0] FN_AND = 6'b110010;
  localparam logic [5:0] FN_OR  = 6'b110011;
  localparam logic [5:0] FN_NOT = 6'b110100;
  localparam logic [5:0] FN_SRA = 6'b111000;
  localparam logic [5:0] FN_SRL = 6'b111001;
  localparam logic [5:0] FN_SLL = 6'b111010;
  localparam logic [5:0] FN_ROL = 6'b111100;
  localparam logic [5:0] FN_ROR = 6'b111101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_ROL = 4'b1100;
  localparam logic [3:0] ALU_ROR = 4'b1101;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_BNE = 3'd4,
    CLS_B   = 3'd5,
    CLS_ILL = 3'd6
  } instr_class_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    ST_HALT   = 3'd6,
`endif
    ST_BRANCH = 3'd5
  } state_e;

  typedef struct packed {
    logic pc_lden;
    logic pc_sel;
    logic rf_wren;
    logic mem_wren;
    logic done;
  } strobe_t;

  // Moore strobes: a function of state and instruction class (plus the zero flag for branches).
  function automatic strobe_t strobes_for(input state_e st, input instr_class_e cls,
                                          input logic zero);
    strobe_t s;
    s = '0;
    case (st)
      ST_MEM: begin
        if (cls == CLS_SW) begin
          s.mem_wren = 1'b1;
          s.pc_lden  = 1'b1;
          s.done     = 1'b1;
        end else begin
          s = '0;
        end
      end
      ST_WB: begin
        s.pc_lden = 1'b1;
        s.done    = 1'b1;
        s.rf_wren = (cls == CLS_ALU) || (cls == CLS_LW);
      end
      ST_BRANCH: begin
        s.pc_lden = 1'b1;
        s.done    = 1'b1;
        case (cls)
          CLS_B:   s.pc_sel = 1'b1;
          CLS_BEQ: s.pc_sel = zero;
          CLS_BNE: s.pc_sel = ~zero;
          default: s.pc_sel = 1'b0;
        endcase
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle. master = control unit, slave = datapath side.
// Illegal exists only when MULTICYCLE_CONTROL_TRAP_EN is defined.
interface multicycle_control_if;
  logic [31:0] Instr;
  logic [31:0] ALU_Out;
  logic [31:0] PC_Immed;
  logic        PC_Sel;
  logic        PC_LdEn;
  logic        RF_WrEn;
  logic        RF_WrData_sel;
  logic        RF_B_sel;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_WrEn;
  logic        Instr_Done;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
  logic        Illegal;
`endif

  modport master (
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    output Illegal,
`endif
    input  Instr, ALU_Out,
    output PC_Immed, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
    output ALU_Bin_sel, ALU_func, Mem_WrEn, Instr_Done
  );

  modport slave (
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    input  Illegal,
`endif
    output Instr, ALU_Out,
    input  PC_Immed, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
    input  ALU_Bin_sel, ALU_func, Mem_WrEn, Instr_Done
  );
endinterface

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational instruction decode: opcode/func -> class, ALU_func, mux selects
// and illegal flag. Selects stay constant while the instruction word is held.
module instr_class_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input  logic [OPC_W-1:0]  opc_i,
  input  logic [FUNC_W-1:0] func_i,
  output instr_class_e      cls_o,
  output logic [3:0]        alu_func_o,
  output logic              alu_bin_sel_o,
  output logic              rf_b_sel_o,
  output logic              rf_wrdata_sel_o,
  output logic              illegal_o
);

  // Opcode/func table; anything not listed falls back to the illegal class with neutral selects.
  always_comb begin
    cls_o           = CLS_ILL;
    alu_func_o      = ALU_ADD;
    alu_bin_sel_o   = 1'b0;
    rf_b_sel_o      = 1'b0;
    rf_wrdata_sel_o = 1'b0;
    case (opc_i)
      OPC_RTYPE: begin
        case (func_i)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOT,
          FN_SRA, FN_SRL, FN_SLL, FN_ROL, FN_ROR: begin
            cls_o      = CLS_ALU;
            alu_func_o = func_i[3:0];
          end
          default: cls_o = CLS_ILL;
        endcase
      end
      OPC_LI, OPC_LUI, OPC_ADDI: begin
        cls_o         = CLS_ALU;
        alu_bin_sel_o = 1'b1;
      end
      OPC_ANDI: begin
        cls_o         = CLS_ALU;
        alu_func_o    = ALU_AND;
        alu_bin_sel_o = 1'b1;
      end
      OPC_ORI: begin
        cls_o         = CLS_ALU;
        alu_func_o    = ALU_OR;
        alu_bin_sel_o = 1'b1;
      end
      OPC_LW: begin
        cls_o           = CLS_LW;
        alu_bin_sel_o   = 1'b1;
        rf_wrdata_sel_o = 1'b1;
      end
      OPC_SW: begin
        cls_o         = CLS_SW;
        alu_bin_sel_o = 1'b1;
        rf_b_sel_o    = 1'b1;
      end
      OPC_BEQ: begin
        cls_o      = CLS_BEQ;
        alu_func_o = ALU_SUB;
        rf_b_sel_o = 1'b1;
      end
      OPC_BNE: begin
        cls_o      = CLS_BNE;
        alu_func_o = ALU_SUB;
        rf_b_sel_o = 1'b1;
      end
      OPC_B:   cls_o = CLS_B;
      default: cls_o = CLS_ILL;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences datapath strobes, holds the branch zero flag.
// Optional trap-on-illegal (HALT state, Illegal output) via MULTICYCLE_CONTROL_TRAP_EN.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  multicycle_control_if.master bus
);

  state_e       state_q, state_d;
  logic         zero_q, zero_d;
  strobe_t      strb_q, strb_d;
  instr_class_e cls_s;
  logic [3:0]   alu_func_s;
  logic         alu_bin_sel_s, rf_b_sel_s, rf_wrdata_sel_s, illegal_s;
  logic         unused_instr_s;

  instr_class_decode #(.OPC_W(OPC_W), .FUNC_W(FUNC_W)) u_dec (
    .opc_i           (bus.Instr[31 -: OPC_W]),
    .func_i          (bus.Instr[FUNC_W-1:0]),
    .cls_o           (cls_s),
    .alu_func_o      (alu_func_s),
    .alu_bin_sel_o   (alu_bin_sel_s),
    .rf_b_sel_o      (rf_b_sel_s),
    .rf_wrdata_sel_o (rf_wrdata_sel_s),
    .illegal_o       (illegal_s)
  );

  assign unused_instr_s = ^bus.Instr[25:16];

  // Next-state logic; zero flag captured only on the EXEC edge.
  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (illegal_s) begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
          state_d = ST_HALT;
`else
          // NOP retire through WB: strobe decode suppresses the RF write for this class.
          state_d = ST_WB;
`endif
        end else if (cls_s == CLS_B) begin
          state_d = ST_BRANCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        zero_d = (bus.ALU_Out == 32'd0);
        case (cls_s)
          CLS_LW, CLS_SW:   state_d = ST_MEM;
          CLS_BEQ, CLS_BNE: state_d = ST_BRANCH;
          default:          state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (cls_s == CLS_LW) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      ST_HALT:   state_d = ST_HALT;
`endif
      default:   state_d = ST_FETCH;
    endcase
  end

  // Strobes are registered from the next state so each output flop mirrors the current state.
  always_comb begin
    strb_d = strobes_for(state_d, cls_s, zero_d);
  end

  // State, zero flag and strobe registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_FETCH;
      zero_q  <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      strb_q  <= strb_d;
    end
  end

`ifdef MULTICYCLE_CONTROL_TRAP_EN
  logic illegal_q;

  // Illegal flag follows HALT; only Reset clears it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (state_d == ST_HALT);
    end
  end

  assign bus.Illegal = illegal_q;
`endif

  assign bus.PC_Immed      = {{14{bus.Instr[15]}}, bus.Instr[15:0], 2'b00};
  assign bus.PC_Sel        = strb_q.pc_sel;
  assign bus.PC_LdEn       = strb_q.pc_lden;
  assign bus.RF_WrEn       = strb_q.rf_wren;
  assign bus.Mem_WrEn      = strb_q.mem_wren;
  assign bus.Instr_Done    = strb_q.done;
  assign bus.RF_WrData_sel = rf_wrdata_sel_s;
  assign bus.RF_B_sel      = rf_b_sel_s;
  assign bus.ALU_Bin_sel   = alu_bin_sel_s;
  assign bus.ALU_func      = alu_func_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction behavioural model
// (class -> cycle count and retire strobes), directed cases plus random instructions.
module tb_multicycle_control;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_B = 5, K_ILL = 6;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  multicycle_control_if bus();
  multicycle_control dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  logic [31:0] e_immed;
  logic [3:0]  e_func;
  logic        e_bin, e_rfb, e_wrsel, e_pcld, e_pcsel, e_rfwr, e_memwr, e_done, e_ill;

  int          obs_done_cyc;
  logic        obs_pcsel;
  logic [31:0] obs_immed;
  logic        obs_ill;

  logic [5:0] legal_funcs [10] = '{6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h38, 6'h39, 6'h3A, 6'h3C, 6'h3D};
  logic [5:0] imm_ops [5] = '{6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d instr=%h actual=%h expected=%h", name, cyc, bus.Instr, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] ins, output int kind, output logic [3:0] fn,
                                     output logic bin, output logic rfb, output logic wrsel);
    logic [5:0] f;
    f = ins[5:0];
    kind = K_ILL; fn = 4'd0; bin = 1'b0; rfb = 1'b0; wrsel = 1'b0;
    case (ins[31:26])
      6'b100000: begin
        if ((f >= 6'h30 && f <= 6'h34) || (f >= 6'h38 && f <= 6'h3A) || f == 6'h3C || f == 6'h3D) begin
          kind = K_ALU; fn = f[3:0];
        end
      end
      6'b111000, 6'b111001, 6'b110000: begin kind = K_ALU; bin = 1'b1; end
      6'b110010: begin kind = K_ALU; bin = 1'b1; fn = 4'b0010; end
      6'b110011: begin kind = K_ALU; bin = 1'b1; fn = 4'b0011; end
      6'b001111: begin kind = K_LW; bin = 1'b1; wrsel = 1'b1; end
      6'b011111: begin kind = K_SW; bin = 1'b1; rfb = 1'b1; end
      6'b000000: begin kind = K_BEQ; fn = 4'b0001; rfb = 1'b1; end
      6'b000001: begin kind = K_BNE; fn = 4'b0001; rfb = 1'b1; end
      6'b111111: kind = K_B;
      default: kind = K_ILL;
    endcase
  endfunction

  function automatic int ref_len(input int kind);
    if (kind == K_LW) return 5;
    if (kind == K_B || kind == K_ILL) return 3;
    return 4;
  endfunction

  task automatic set_exp(input logic [31:0] ins, input logic [31:0] aluv, input int c, input bit in_rst);
    int kind, n;
    bit halt_mode, retire;
    logic signed [31:0] off;
    ref_decode(ins, kind, e_func, e_bin, e_rfb, e_wrsel);
    n = ref_len(kind);
    halt_mode = TRAP_ON && (kind == K_ILL);
    retire = !in_rst && !halt_mode && (c == n);
    off = $signed(ins[15:0]);
    e_immed = off * 32'sd4;
    e_pcld  = retire;
    e_done  = retire;
    e_rfwr  = retire && (kind == K_ALU || kind == K_LW);
    e_memwr = retire && (kind == K_SW);
    e_pcsel = retire && (kind == K_B || (kind == K_BEQ && aluv == 32'd0) || (kind == K_BNE && aluv != 32'd0));
    e_ill   = !in_rst && halt_mode && (c >= 3);
  endtask

  // Single compare process: every output, every cycle, at the falling edge.
  initial begin
    forever begin
      @(negedge Clk);
      if (cmp_en) begin
        chk("PC_Immed", bus.PC_Immed, e_immed);
        chk("ALU_func", {28'd0, bus.ALU_func}, {28'd0, e_func});
        chk("ALU_Bin_sel", {31'd0, bus.ALU_Bin_sel}, {31'd0, e_bin});
        chk("RF_B_sel", {31'd0, bus.RF_B_sel}, {31'd0, e_rfb});
        chk("RF_WrData_sel", {31'd0, bus.RF_WrData_sel}, {31'd0, e_wrsel});
        chk("PC_LdEn", {31'd0, bus.PC_LdEn}, {31'd0, e_pcld});
        chk("PC_Sel", {31'd0, bus.PC_Sel}, {31'd0, e_pcsel});
        chk("RF_WrEn", {31'd0, bus.RF_WrEn}, {31'd0, e_rfwr});
        chk("Mem_WrEn", {31'd0, bus.Mem_WrEn}, {31'd0, e_memwr});
        chk("Instr_Done", {31'd0, bus.Instr_Done}, {31'd0, e_done});
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        chk("Illegal", {31'd0, bus.Illegal}, {31'd0, e_ill});
        if (bus.Illegal === 1'b1) obs_ill = 1'b1;
`endif
        if (bus.Instr_Done === 1'b1) begin
          obs_done_cyc = cyc;
          obs_pcsel = bus.PC_Sel;
        end
        obs_immed = bus.PC_Immed;
      end
    end
  end

  // Runs one instruction from FETCH; abort_at>0 pulls Reset low in that cycle.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] aluv, input int abort_at);
    int kind, total;
    logic [3:0] fn;
    logic b0, b1, b2;
    ref_decode(ins, kind, fn, b0, b1, b2);
    total = (TRAP_ON && kind == K_ILL) ? 7 : ref_len(kind);
    bus.Instr = ins;
    bus.ALU_Out = aluv;
    obs_done_cyc = 0;
    obs_pcsel = 1'b0;
    obs_ill = 1'b0;
    for (int c = 1; c <= total; c++) begin
      if (c > 1) begin
        @(posedge Clk); #2;
      end
      cyc = c;
      set_exp(ins, aluv, c, 1'b0);
      // zero flag must already be latched; disturb ALU_Out in the branch cycle
      if ((kind == K_BEQ || kind == K_BNE) && c == 4) bus.ALU_Out = $urandom;
      if (c == abort_at) begin
        Reset = 1'b0;
        set_exp(ins, aluv, c, 1'b1);
        @(posedge Clk); #2;
        @(posedge Clk); #2;
        Reset = 1'b1;
        return;
      end
    end
    if (TRAP_ON && kind == K_ILL) begin
      Reset = 1'b0;
      set_exp(ins, aluv, total, 1'b1);
      @(posedge Clk); #2;
      Reset = 1'b1;
    end else begin
      @(posedge Clk); #2;
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int kind;
    logic [3:0] fn;
    logic b0, b1, b2;
    int k;
    k = $urandom_range(0, 9);
    ins = $urandom;
    case (k)
      0: begin ins[31:26] = 6'b100000; ins[5:0] = legal_funcs[$urandom_range(0, 9)]; end
      1: ins[31:26] = imm_ops[$urandom_range(0, 4)];
      2: ins[31:26] = 6'b001111;
      3: ins[31:26] = 6'b011111;
      4, 9: ins[31:26] = 6'b000000;
      5: ins[31:26] = 6'b000001;
      6: ins[31:26] = 6'b111111;
      7: begin
        do begin
          ins = $urandom;
          ref_decode(ins, kind, fn, b0, b1, b2);
        end while (kind != K_ILL);
      end
      default: begin
        do begin
          ins[5:0] = 6'($urandom_range(0, 63));
          ins[31:26] = 6'b100000;
          ref_decode(ins, kind, fn, b0, b1, b2);
        end while (kind != K_ILL);
      end
    endcase
    return ins;
  endfunction

  logic [31:0] addi_i, add_i, lw_i, sw_i, beq_i, bne_i, b_i, ill_i, rnd_i, rnd_alu;

  initial begin
    addi_i = {6'b110000, 5'd1, 5'd2, 16'h0007};
    add_i  = {6'b100000, 5'd3, 5'd4, 5'd5, 5'd0, 6'b110000};
    lw_i   = {6'b001111, 5'd1, 5'd2, 16'h0004};
    sw_i   = {6'b011111, 5'd1, 5'd2, 16'h0008};
    beq_i  = {6'b000000, 5'd1, 5'd2, 16'hFFFE};
    bne_i  = {6'b000001, 5'd1, 5'd2, 16'hFFFE};
    b_i    = {6'b111111, 5'd0, 5'd0, 16'h0010};
    ill_i  = {6'b101010, 5'd0, 5'd0, 16'h0000};

    bus.Instr = addi_i;
    bus.ALU_Out = 32'd0;
    cyc = 0;
    set_exp(addi_i, 32'd0, 0, 1'b1);
    @(posedge Clk); #2;
    cmp_en = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b1;

    run_instr(addi_i, 32'd9, 3);
    run_instr(addi_i, 32'd9, 0);
    chk("addi_retire_cycle", obs_done_cyc, 32'd4);

    run_instr(add_i, 32'd1, 0);
    chk("add_retire_cycle", obs_done_cyc, 32'd4);
    run_instr(lw_i, 32'd1, 0);
    chk("lw_retire_cycle", obs_done_cyc, 32'd5);
    run_instr(sw_i, 32'd1, 0);
    chk("sw_retire_cycle", obs_done_cyc, 32'd4);

    run_instr(beq_i, 32'd0, 0);
    chk("beq_immed", obs_immed, 32'hFFFFFFF8);
    chk("beq_zero_pcsel", {31'd0, obs_pcsel}, 32'd1);
    run_instr(beq_i, 32'd5, 0);
    chk("beq_nonzero_pcsel", {31'd0, obs_pcsel}, 32'd0);
    run_instr(bne_i, 32'd0, 0);
    chk("bne_zero_pcsel", {31'd0, obs_pcsel}, 32'd0);
    run_instr(bne_i, 32'd5, 0);
    chk("bne_nonzero_pcsel", {31'd0, obs_pcsel}, 32'd1);
    chk("bne_retire_cycle", obs_done_cyc, 32'd4);

    run_instr(b_i, 32'd3, 0);
    chk("b_retire_cycle", obs_done_cyc, 32'd3);
    chk("b_pcsel", {31'd0, obs_pcsel}, 32'd1);

    run_instr(ill_i, 32'd0, 0);
    if (TRAP_ON) begin
      chk("ill_no_retire", obs_done_cyc, 32'd0);
      chk("ill_halt_flag", {31'd0, obs_ill}, 32'd1);
    end else begin
      chk("ill_retire_cycle", obs_done_cyc, 32'd3);
      chk("ill_pcsel", {31'd0, obs_pcsel}, 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      rnd_i = gen_instr();
      rnd_alu = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      run_instr(rnd_i, rnd_alu, ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
